// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, forward selects and the
// multiplier FSM state type used by the execute stage.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage. Multiply is not computed here;
// op 100 and the unused codes 110/111 produce 0.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Select the operation result and derive the zero flag for branch resolution.
  always_comb begin
    result = {XLEN{1'b0}};
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = {XLEN{1'b0}};
    endcase
    zero = (result == {XLEN{1'b0}});
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the five-stage RV32I pipeline: operand forwarding, ALU,
// beq resolution and the EX/MEM pipeline register.
// Optional feature macro: EXECUTE_MUL_EN adds an iterative shift-add
// multiplier (op 100) that stalls the front of the pipe while it runs.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite_e,
  input  logic            memwrite_e,
  input  logic            resultsrc_e,
  input  logic            branch_e,
  input  logic            alusrc_e,
  input  logic [2:0]      alucontrol_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pcplus4_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      forwardae,
  input  logic [1:0]      forwardbe,
  input  logic [XLEN-1:0] result_w,
  output logic            pcsrc_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic            busy_e,
  output logic            regwrite_m,
  output logic            memwrite_m,
  output logic            resultsrc_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] aluresult_m,
  output logic [XLEN-1:0] writedata_m,
  output logic [XLEN-1:0] pcplus4_m
);

  logic [XLEN-1:0] src_a_s;
  logic [XLEN-1:0] wd_s;
  logic [XLEN-1:0] src_b_s;
  logic [XLEN-1:0] alu_result_s;
  logic            zero_s;
  logic [XLEN-1:0] ex_result_s;
  logic            bubble_s;
  logic            busy_s;

  // Forwarding muxes; select 11 falls back to the register-file value.
  always_comb begin
    src_a_s = rd1_e;
    wd_s    = rd2_e;
    case (forwardae)
      FWD_WB:  src_a_s = result_w;
      FWD_MEM: src_a_s = aluresult_m;
      default: src_a_s = rd1_e;
    endcase
    case (forwardbe)
      FWD_WB:  wd_s = result_w;
      FWD_MEM: wd_s = aluresult_m;
      default: wd_s = rd2_e;
    endcase
  end

  assign src_b_s = alusrc_e ? imm_ext_e : wd_s;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (src_a_s),
    .b      (src_b_s),
    .op     (alucontrol_e),
    .result (alu_result_s),
    .zero   (zero_s)
  );

  assign pcsrc_e    = branch_e & zero_s;
  assign pctarget_e = pc_e + imm_ext_e;
  assign busy_e     = busy_s;

`ifdef EXECUTE_MUL_EN
  mul_state_t      state_r;
  logic [XLEN-1:0] mul_a_r;
  logic [XLEN-1:0] mul_b_r;
  logic [XLEN-1:0] prod_r;
  logic [4:0]      count_r;

  // Multiplier FSM: latch operands once, then one shift-add step per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MUL_IDLE;
      mul_a_r <= {XLEN{1'b0}};
      mul_b_r <= {XLEN{1'b0}};
      prod_r  <= {XLEN{1'b0}};
      count_r <= 5'd0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (alucontrol_e == ALU_MUL) begin
            mul_a_r <= src_a_s;
            mul_b_r <= src_b_s;
            prod_r  <= {XLEN{1'b0}};
            count_r <= 5'd0;
            state_r <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mul_b_r[0]) begin
            prod_r <= prod_r + mul_a_r;
          end
          mul_a_r <= mul_a_r << 1;
          mul_b_r <= mul_b_r >> 1;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= MUL_DONE;
          end
        end
        MUL_DONE: state_r <= MUL_IDLE;
        default:  state_r <= MUL_IDLE;
      endcase
    end
  end

  // Stall/bubble decode and choice of the value written into EX/MEM.
  always_comb begin
    busy_s      = 1'b0;
    bubble_s    = 1'b0;
    ex_result_s = alu_result_s;
    case (state_r)
      MUL_IDLE: begin
        if (alucontrol_e == ALU_MUL) begin
          busy_s   = 1'b1;
          bubble_s = 1'b1;
        end else begin
          busy_s   = 1'b0;
          bubble_s = 1'b0;
        end
      end
      MUL_RUN: begin
        busy_s   = 1'b1;
        bubble_s = 1'b1;
      end
      MUL_DONE: ex_result_s = prod_r;
      default: begin
        busy_s      = 1'b0;
        bubble_s    = 1'b0;
        ex_result_s = alu_result_s;
      end
    endcase
  end
`else
  assign busy_s      = 1'b0;
  assign bubble_s    = 1'b0;
  assign ex_result_s = alu_result_s;
`endif

  // EX/MEM pipeline register; a bubble kills the write side effects and rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= 1'b0;
      rd_m        <= 5'd0;
      aluresult_m <= {XLEN{1'b0}};
      writedata_m <= {XLEN{1'b0}};
      pcplus4_m   <= {XLEN{1'b0}};
    end else begin
      regwrite_m  <= regwrite_e & ~bubble_s;
      memwrite_m  <= memwrite_e & ~bubble_s;
      resultsrc_m <= resultsrc_e;
      rd_m        <= bubble_s ? 5'd0 : rd_e;
      aluresult_m <= ex_result_s;
      writedata_m <= wd_s;
      pcplus4_m   <= pcplus4_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage. Multiplier scenarios are
// selected by EXECUTE_MUL_EN to match the build of the design.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_e, memwrite_e, resultsrc_e, branch_e, alusrc_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e, result_w;
  logic [4:0]  rd_e;
  logic [1:0]  forwardae, forwardbe;
  logic        pcsrc_e, busy_e, regwrite_m, memwrite_m, resultsrc_m;
  logic [31:0] pctarget_e, aluresult_m, writedata_m, pcplus4_m;
  logic [4:0]  rd_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e),
    .branch_e(branch_e), .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pcplus4_e(pcplus4_e), .rd_e(rd_e), .forwardae(forwardae), .forwardbe(forwardbe),
    .result_w(result_w), .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .busy_e(busy_e),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m),
    .rd_m(rd_m), .aluresult_m(aluresult_m), .writedata_m(writedata_m), .pcplus4_m(pcplus4_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    regwrite_e = 1'b0; memwrite_e = 1'b0; resultsrc_e = 1'b0; branch_e = 1'b0;
    alusrc_e = 1'b0; alucontrol_e = 3'b000; rd1_e = 32'd0; rd2_e = 32'd0;
    imm_ext_e = 32'd0; pc_e = 32'd0; pcplus4_e = 32'd0; rd_e = 5'd0;
    forwardae = 2'b00; forwardbe = 2'b00; result_w = 32'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    regwrite_e = 1'b1; memwrite_e = 1'b1; rd_e = 5'd3; rd1_e = 32'd9; pcplus4_e = 32'h44;
    rst = 1'b0;
    step(); step();
    n_vec++; if (aluresult_m !== 32'd0) begin n_err++; $display("FAIL reset_alu: got %h want %h", aluresult_m, 32'd0); end
    n_vec++; if ({regwrite_m, memwrite_m, resultsrc_m, rd_m} !== 8'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", {regwrite_m, memwrite_m, resultsrc_m, rd_m}, 8'd0); end
    n_vec++; if ({writedata_m, pcplus4_m} !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h want %h", {writedata_m, pcplus4_m}, 64'd0); end
    n_vec++; if (busy_e !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want %b", busy_e, 1'b0); end
    rst = 1'b1;
    clear_inputs();
    step();
  endtask

  task automatic test_add();
    clear_inputs();
    rd1_e = 32'd5; rd2_e = 32'd7; alucontrol_e = 3'b000; regwrite_e = 1'b1;
    resultsrc_e = 1'b1; rd_e = 5'd7; pcplus4_e = 32'h104;
    step();
    n_vec++; if (aluresult_m !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want %h", aluresult_m, 32'd12); end
    n_vec++; if (writedata_m !== 32'd7) begin n_err++; $display("FAIL add_wdata: got %h want %h", writedata_m, 32'd7); end
    n_vec++; if ({regwrite_m, memwrite_m, resultsrc_m, rd_m, pcplus4_m} !== {1'b1, 1'b0, 1'b1, 5'd7, 32'h104}) begin
      n_err++; $display("FAIL add_ctrl: got %b%b%b rd=%0d pc4=%h want 101 rd=7 pc4=104", regwrite_m, memwrite_m, resultsrc_m, rd_m, pcplus4_m);
    end
    // Immediate as operand B; store data still comes from the B forward path.
    rd1_e = 32'd3; rd2_e = 32'h55; imm_ext_e = 32'd4; alusrc_e = 1'b1; memwrite_e = 1'b1; regwrite_e = 1'b0;
    step();
    n_vec++; if ({aluresult_m, writedata_m} !== {32'd7, 32'h55}) begin n_err++; $display("FAIL imm_add: got %h/%h want %h/%h", aluresult_m, writedata_m, 32'd7, 32'h55); end
    n_vec++; if ({regwrite_m, memwrite_m} !== 2'b01) begin n_err++; $display("FAIL imm_ctrl: got %b want %b", {regwrite_m, memwrite_m}, 2'b01); end
    alusrc_e = 1'b0; memwrite_e = 1'b0;
    // and / or / unused op 110.
    rd1_e = 32'hF0F0_00FF; rd2_e = 32'h0FF0_0F0F; alucontrol_e = 3'b010;
    step();
    n_vec++; if (aluresult_m !== 32'h00F0_000F) begin n_err++; $display("FAIL and_result: got %h want %h", aluresult_m, 32'h00F0_000F); end
    alucontrol_e = 3'b011;
    step();
    n_vec++; if (aluresult_m !== 32'hFFF0_0FFF) begin n_err++; $display("FAIL or_result: got %h want %h", aluresult_m, 32'hFFF0_0FFF); end
    alucontrol_e = 3'b110;
    step();
    n_vec++; if (aluresult_m !== 32'd0) begin n_err++; $display("FAIL op110_result: got %h want %h", aluresult_m, 32'd0); end
  endtask

  task automatic test_forward();
    clear_inputs();
    rd1_e = 32'h8; rd2_e = 32'h8;
    step();
    // A from MEM stage (previous result 0x10).
    rd1_e = 32'h99; rd2_e = 32'd1; alucontrol_e = 3'b001; forwardae = 2'b10;
    step();
    n_vec++; if (aluresult_m !== 32'h0F) begin n_err++; $display("FAIL fwd_mem_a: got %h want %h", aluresult_m, 32'h0F); end
    forwardae = 2'b01; result_w = 32'd3;
    step();
    n_vec++; if (aluresult_m !== 32'd2) begin n_err++; $display("FAIL fwd_wb_a: got %h want %h", aluresult_m, 32'd2); end
    forwardae = 2'b11; rd1_e = 32'h20;
    step();
    n_vec++; if (aluresult_m !== 32'h1F) begin n_err++; $display("FAIL fwd_11_a: got %h want %h", aluresult_m, 32'h1F); end
    // B from MEM stage feeds both the ALU and the store data.
    forwardae = 2'b00; forwardbe = 2'b10; rd1_e = 32'd1; rd2_e = 32'h77; alucontrol_e = 3'b000;
    step();
    n_vec++; if ({aluresult_m, writedata_m} !== {32'h20, 32'h1F}) begin n_err++; $display("FAIL fwd_mem_b: got %h/%h want %h/%h", aluresult_m, writedata_m, 32'h20, 32'h1F); end
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_e = 1'b1; alucontrol_e = 3'b001; rd1_e = 32'd9; rd2_e = 32'd9;
    pc_e = 32'h100; imm_ext_e = 32'h20;
    #1;
    n_vec++; if ({pcsrc_e, pctarget_e} !== {1'b1, 32'h120}) begin n_err++; $display("FAIL beq_taken: got %b/%h want %b/%h", pcsrc_e, pctarget_e, 1'b1, 32'h120); end
    rd2_e = 32'd8;
    #1;
    n_vec++; if (pcsrc_e !== 1'b0) begin n_err++; $display("FAIL beq_not_taken: got %b want %b", pcsrc_e, 1'b0); end
    step();
  endtask

  task automatic test_slt();
    clear_inputs();
    alucontrol_e = 3'b101; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1;
    step();
    n_vec++; if (aluresult_m !== 32'd1) begin n_err++; $display("FAIL slt_neg: got %h want %h", aluresult_m, 32'd1); end
    rd1_e = 32'd1; rd2_e = 32'hFFFF_FFFF;
    step();
    n_vec++; if (aluresult_m !== 32'd0) begin n_err++; $display("FAIL slt_pos: got %h want %h", aluresult_m, 32'd0); end
    // Add wraps to zero; zero flag observed through the branch output.
    alucontrol_e = 3'b000; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; branch_e = 1'b1;
    #1;
    n_vec++; if (pcsrc_e !== 1'b1) begin n_err++; $display("FAIL add_wrap_zero: got %b want %b", pcsrc_e, 1'b1); end
    step();
    n_vec++; if (aluresult_m !== 32'd0) begin n_err++; $display("FAIL add_wrap: got %h want %h", aluresult_m, 32'd0); end
    branch_e = 1'b0;
  endtask

  // Runs one multiply whose operands are already on the inputs; returns the
  // number of busy cycles and the number of non-bubble EX/MEM loads seen.
  task automatic run_mul(output int busy_cycles, output int bubble_bad);
    busy_cycles = 0;
    bubble_bad  = 0;
    while (busy_e === 1'b1 && busy_cycles < 60) begin
      busy_cycles++;
      step();
      if (busy_cycles == 1) forwardae = 2'b10;
      if (rd_m !== 5'd0 || regwrite_m !== 1'b0 || memwrite_m !== 1'b0) bubble_bad++;
    end
    forwardae = 2'b00;
  endtask

  task automatic test_mul();
    int cyc;
    int bad;
    clear_inputs();
    alucontrol_e = 3'b100; rd1_e = 32'h0000_FFFF; rd2_e = 32'h0001_0001;
    regwrite_e = 1'b1; rd_e = 5'd9;
`ifdef EXECUTE_MUL_EN
    #1;
    n_vec++; if (busy_e !== 1'b1) begin n_err++; $display("FAIL mul_busy_start: got %b want %b", busy_e, 1'b1); end
    run_mul(cyc, bad);
    n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want %0d", cyc, 33); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mul_bubbles: got %0d non-bubble loads want %0d", bad, 0); end
    step();
    n_vec++; if ({aluresult_m, rd_m, regwrite_m} !== {32'hFFFF_FFFF, 5'd9, 1'b1}) begin
      n_err++; $display("FAIL mul_result: got %h rd=%0d rw=%b want ffffffff rd=9 rw=1", aluresult_m, rd_m, regwrite_m);
    end
    // Second mul follows immediately.
    rd1_e = 32'd3; rd2_e = 32'd5; rd_e = 5'd10;
    n_vec++; if (busy_e !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want %b", busy_e, 1'b1); end
    run_mul(cyc, bad);
    n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, 33); end
    step();
    n_vec++; if ({aluresult_m, rd_m} !== {32'd15, 5'd10}) begin n_err++; $display("FAIL b2b_result: got %h rd=%0d want %h rd=%0d", aluresult_m, rd_m, 32'd15, 5'd10); end
`else
    #1;
    n_vec++; if (busy_e !== 1'b0) begin n_err++; $display("FAIL nomul_busy: got %b want %b", busy_e, 1'b0); end
    step();
    n_vec++; if ({aluresult_m, rd_m, regwrite_m} !== {32'd0, 5'd9, 1'b1}) begin
      n_err++; $display("FAIL nomul_result: got %h rd=%0d rw=%b want 0 rd=9 rw=1", aluresult_m, rd_m, regwrite_m);
    end
`endif
    alucontrol_e = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_mul();
    clear_inputs();
    alucontrol_e = 3'b100; rd1_e = 32'd7; rd2_e = 32'd6; regwrite_e = 1'b1; rd_e = 5'd12;
    for (int i = 0; i < 11; i++) step();
    rst = 1'b0;
    alucontrol_e = 3'b000;
    #1;
    n_vec++; if ({aluresult_m, rd_m, regwrite_m, memwrite_m} !== {32'd0, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL midmul_reset_out: got %h rd=%0d rw=%b want 0 rd=0 rw=0", aluresult_m, rd_m, regwrite_m);
    end
    n_vec++; if (busy_e !== 1'b0) begin n_err++; $display("FAIL midmul_reset_busy: got %b want %b", busy_e, 1'b0); end
    step();
    rst = 1'b1;
    rd1_e = 32'd2; rd2_e = 32'd3; rd_e = 5'd4;
    step();
    n_vec++; if ({aluresult_m, rd_m, regwrite_m} !== {32'd5, 5'd4, 1'b1}) begin
      n_err++; $display("FAIL post_reset_add: got %h rd=%0d rw=%b want 5 rd=4 rw=1", aluresult_m, rd_m, regwrite_m);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_slt();
    test_mul();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the five-stage RV32I pipeline, directly downstream of the hazard unit. It consumes the `forwardae`/`forwardbe` selects and resolves operands from the ID/EX register, MEM-stage result or WB-stage result. It runs the ALU, resolves `beq`, and holds the EX/MEM pipeline register. It optionally contains an iterative multiplier that stalls the front of the pipe.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `regwrite_e`, `memwrite_e`, `resultsrc_e`, `branch_e`, `alusrc_e`, in, 1 each: ID/EX control.
- `alucontrol_e`, in, 3: operation. 000 add, 001 sub, 010 and, 011 or, 101 slt, 100 mul (macro only). 110 and 111 give a result of 0.
- `rd1_e`, `rd2_e`, `imm_ext_e`, `pc_e`, `pcplus4_e`, in, XLEN each: ID/EX data.
- `rd_e`, in, 5: destination register.
- `forwardae`, `forwardbe`, in, 2 each: operand selects. 00 = register file, 01 = `result_w`, 10 = `aluresult_m`, 11 = treated as 00.
- `result_w`, in, XLEN: writeback value.
- `pcsrc_e`, out, 1: branch taken (combinational).
- `pctarget_e`, out, XLEN: `pc_e + imm_ext_e` (combinational).
- `busy_e`, out, 1: stall request to IF/ID/ID-EX. Tied to 0 without the macro.
- `regwrite_m`, `memwrite_m`, `resultsrc_m`, out, 1 each: registered control.
- `rd_m`, out, 5: registered destination register.
- `aluresult_m`, `writedata_m`, `pcplus4_m`, out, XLEN each: registered data.

## Operation
- Operand A = forward mux A output. `wd_e` = forward mux B output. Operand B = `imm_ext_e` when `alusrc_e` is set, else `wd_e`.
- Add and sub wrap modulo 2^XLEN. slt is a signed compare: 1 or 0, zero-extended.
- `zero_e` = (ALU result == 0). `pcsrc_e` = `branch_e & zero_e`.
- EX/MEM register loads the ALU result, `wd_e`, `pcplus4_e`, `rd_e` and the control bits every cycle unless the multiplier FSM decides otherwise.
- Multiplier FSM (macro only) has three states: IDLE, RUN, DONE.
  - IDLE with op 100: latch A and B, clear the product accumulator and the 5-bit counter, then go to RUN. EX/MEM loads a bubble.
  - RUN: one shift-add step per cycle. Counter increments from 0 to 31. After the step at count 31, go to DONE. EX/MEM loads a bubble each cycle.
  - DONE: EX/MEM loads the low XLEN bits of the product with the mul instruction's control and `rd_e`. Return to IDLE.
- A bubble clears `regwrite_m` and `memwrite_m` and clears `rd_m` to 0. Older instructions therefore drain through MEM/WB.
- `busy_e` = 1 in IDLE-with-mul and in RUN, 0 in DONE. Upstream holds ID/EX stable throughout.
- Operands are latched in the first cycle, so forwarding changes during the stall are ignored.

## Timing
- Reset (`rst` = 0, asynchronous): all EX/MEM outputs are 0, FSM goes to IDLE, counter is 0, `busy_e` is 0. Reset mid-multiply aborts it with no writeback.
- Non-mul ops: 1 cycle in EX. The result is visible on `aluresult_m` one edge after the instruction appears on the `_e` inputs.
- `pcsrc_e` and `pctarget_e` are valid in the same cycle, with no register.
- Mul: 34 cycles in EX, with `busy_e` high for 33 of them. The product appears on `aluresult_m` at the edge that leaves DONE.
- Back-to-back muls: the second one enters IDLE-with-mul on the cycle after DONE.

## Configuration
- `EXECUTE_MUL_EN` defined: multiplier FSM and op 100 are present.
- `EXECUTE_MUL_EN` undefined: op 100 gives a result of 0, there is no FSM, `busy_e` is constant 0, and EX/MEM loads every cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op constants (`ALU_ADD` … `ALU_MUL`).
  - Forward select constants (`FWD_RF`, `FWD_WB`, `FWD_MEM`).
  - The `mul_state_t` enum.
- One sub-module, `alu`: combinational; operands, op, result, zero. The multiplier FSM stays in `execute_stage`.

## Test plan
- Add without forwarding: rd1 = 5, rd2 = 7, op 000, `alusrc_e` = 0 → `aluresult_m` = 12 after 1 edge, `writedata_m` = 7.
- MEM forward: `forwardae` = 10, previous result 0x10, rd2 = 1, sub → 0x0F. Select 01 with `result_w` = 3 → uses 3. Select 11 → uses rd1.
- Branch: `branch_e` = 1, operands equal with sub → `pcsrc_e` = 1 and `pctarget_e` = `pc_e + imm` in the same cycle. Unequal → `pcsrc_e` = 0.
- slt: A = 0xFFFFFFFF, B = 1 → 1. Add 0xFFFFFFFF + 1 → 0 with `zero_e` = 1.
- Mul (macro on): 0x0000FFFF × 0x00010001 → `busy_e` high for 33 cycles with bubbles in MEM, then `aluresult_m` = 0xFFFFFFFF.
- Reset mid-mul at count 10 → outputs 0, `busy_e` 0. A subsequent add completes in 1 cycle.
